// File: rtl/cps3_linebuf_writer.sv
// CPS3 capture side: turns the source video stream into line-buffer writes and
// measures the source line length and frame height.
module cps3_linebuf_writer #(
  parameter int NUM_LINE_BUFFERS = 40,
  parameter int H_CNT_MAX        = 4095
) (
  input  logic        PCLK,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
  input  logic [31:0] h_info,
  input  logic [31:0] v_info,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [5:0]  wr_line,
  output logic [23:0] wr_data,
  output logic        frame_start,
  output logic [10:0] lines_per_frame,
  output logic [11:0] pix_per_line,
  output logic        sync_lost
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    WAIT_HS = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [11:0] HMAX      = 12'(H_CNT_MAX);
  localparam logic [5:0]  LAST_SLOT = 6'(NUM_LINE_BUFFERS - 1);

  state_t      state_r, state_nxt_s;
  logic        prev_hs_r, prev_vs_r;
  logic [11:0] hcnt_r, hcnt_nxt_s;
  logic [10:0] vcnt_r, vcnt_nxt_s;
  logic [9:0]  h_start_r;
  logic [8:0]  h_active_r;
  logic [5:0]  v_start_r;
  logic [8:0]  v_active_r;
  logic        first_done_r;

  logic        hs_fall_s, vs_fall_s, line_fall_s, wait_hs_done_s, loss_s;
  logic [10:0] h_end_s;
  logic [9:0]  v_end_s;
  logic        line_active_s, pix_active_s, frame_hit_s, end_active_s;
  logic        unused_cfg_s;

  assign hs_fall_s      = pix_ce & prev_hs_r & ~HSYNC_in;
  assign vs_fall_s      = pix_ce & prev_vs_r & ~VSYNC_in;
  // A coincident VSYNC fall owns the edge; the HSYNC fall only resets hcnt.
  assign line_fall_s    = hs_fall_s & ~vs_fall_s;
  assign wait_hs_done_s = (state_r == WAIT_HS) & line_fall_s;
  assign loss_s         = pix_ce & ~hs_fall_s & (hcnt_r == (HMAX - 12'd1));

  assign h_end_s = {1'b0, h_start_r} + {2'b00, h_active_r};
  assign v_end_s = {4'b0000, v_start_r} + {1'b0, v_active_r};

  assign line_active_s = (state_r == RUN) && (vcnt_r >= {5'd0, v_start_r}) &&
                         (vcnt_r < {1'b0, v_end_s});
  assign pix_active_s  = line_active_s && pix_ce && !hs_fall_s && !vs_fall_s &&
                         (hcnt_r >= {2'b00, h_start_r}) && (hcnt_r < {1'b0, h_end_s});
  assign frame_hit_s   = line_fall_s && ((state_r == RUN) || wait_hs_done_s) &&
                         (vcnt_nxt_s == {5'd0, v_start_r});
  assign end_active_s  = line_fall_s && line_active_s;

  assign unused_cfg_s = ^{h_info[31:25], h_info[15:10], v_info[31:25], v_info[15:6]};

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      prev_hs_r <= 1'b1;
      prev_vs_r <= 1'b1;
    end else if (pix_ce) begin
      prev_hs_r <= HSYNC_in;
      prev_vs_r <= VSYNC_in;
    end else begin
      prev_hs_r <= prev_hs_r;
      prev_vs_r <= prev_vs_r;
    end
  end

  // Geometry is only accepted while the source is in vsync.
  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      h_start_r  <= 10'd0;
      h_active_r <= 9'd0;
      v_start_r  <= 6'd0;
      v_active_r <= 9'd0;
    end else if (pix_ce && !VSYNC_in) begin
      h_start_r  <= h_info[9:0];
      h_active_r <= h_info[24:16];
      v_start_r  <= v_info[5:0];
      v_active_r <= v_info[24:16];
    end else begin
      h_start_r  <= h_start_r;
      h_active_r <= h_active_r;
      v_start_r  <= v_start_r;
      v_active_r <= v_active_r;
    end
  end

  always_comb begin
    hcnt_nxt_s = hcnt_r;
    if (pix_ce && hs_fall_s) begin
      hcnt_nxt_s = 12'd0;
    end else if (pix_ce && (hcnt_r != HMAX)) begin
      hcnt_nxt_s = hcnt_r + 12'd1;
    end else begin
      hcnt_nxt_s = hcnt_r;
    end

    vcnt_nxt_s = vcnt_r;
    if (wait_hs_done_s) begin
      vcnt_nxt_s = 11'd0;
    end else if (line_fall_s && (vcnt_r != 11'd2047)) begin
      vcnt_nxt_s = vcnt_r + 11'd1;
    end else begin
      vcnt_nxt_s = vcnt_r;
    end
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r          <= 12'd0;
      vcnt_r          <= 11'd0;
      pix_per_line    <= 12'd0;
      lines_per_frame <= 11'd0;
      first_done_r    <= 1'b0;
      sync_lost       <= 1'b0;
    end else begin
      hcnt_r <= hcnt_nxt_s;
      vcnt_r <= vcnt_nxt_s;
      if (line_fall_s) begin
        pix_per_line <= (hcnt_r == HMAX) ? HMAX : (hcnt_r + 12'd1);
      end
      // The first frame after reset has no known start, so it is not measured.
      if (wait_hs_done_s) begin
        first_done_r <= 1'b1;
        if (first_done_r) begin
          lines_per_frame <= vcnt_r + 11'd1;
        end
      end
      if (hs_fall_s) begin
        sync_lost <= 1'b0;
      end else if (loss_s) begin
        sync_lost <= 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= WAIT_VS;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    if (loss_s) begin
      state_nxt_s = WAIT_VS;
    end else begin
      case (state_r)
        WAIT_VS: state_nxt_s = vs_fall_s ? WAIT_HS : WAIT_VS;
        WAIT_HS: state_nxt_s = vs_fall_s ? WAIT_HS : (hs_fall_s ? RUN : WAIT_HS);
        RUN:     state_nxt_s = vs_fall_s ? WAIT_HS : RUN;
        default: state_nxt_s = WAIT_VS;
      endcase
    end
  end

  // Slot index restarts at the first active line and otherwise advances per active line.
  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_line     <= 6'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_hit_s;
      if (frame_hit_s) begin
        wr_line <= 6'd0;
      end else if (end_active_s) begin
        wr_line <= (wr_line == LAST_SLOT) ? 6'd0 : (wr_line + 6'd1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= 9'd0;
      wr_data <= 24'd0;
    end else if (pix_active_s) begin
      wr_en   <= 1'b1;
      wr_addr <= 9'(hcnt_r - {2'b00, h_start_r});
      wr_data <= {R_in, G_in, B_in};
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cps3_linebuf_writer.sv
// Directed bench for cps3_linebuf_writer: 64-pixel, 52-line synthetic source
// with a 40x44 window; pixel data encodes line and position for checking.
module tb_cps3_linebuf_writer;

  logic        PCLK = 1'b0;
  logic        reset_n;
  logic        pix_ce;
  logic        HSYNC_in;
  logic        VSYNC_in;
  logic [7:0]  R_in, G_in, B_in;
  logic [31:0] h_info, v_info;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [5:0]  wr_line;
  logic [23:0] wr_data;
  logic        frame_start;
  logic [10:0] lines_per_frame;
  logic [11:0] pix_per_line;
  logic        sync_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int fs_count = 0;
  bit got_first = 1'b0;
  int first_line = -1;
  int mon_r;
  int h_start_exp  = 8;
  int h_active_exp = 40;
  int v_start_exp  = 4;
  int v_active_exp = 44;

  cps3_linebuf_writer dut (
    .PCLK            (PCLK),
    .reset_n         (reset_n),
    .pix_ce          (pix_ce),
    .HSYNC_in        (HSYNC_in),
    .VSYNC_in        (VSYNC_in),
    .R_in            (R_in),
    .G_in            (G_in),
    .B_in            (B_in),
    .h_info          (h_info),
    .v_info          (v_info),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_line         (wr_line),
    .wr_data         (wr_data),
    .frame_start     (frame_start),
    .lines_per_frame (lines_per_frame),
    .pix_per_line    (pix_per_line),
    .sync_lost       (sync_lost)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write must carry its own position: G = hcnt, R = source line.
  always @(negedge PCLK) begin
    if (frame_start === 1'b1) fs_count++;
    if (wr_en === 1'b1) begin
      wr_count++;
      if (!got_first) begin
        got_first  = 1'b1;
        first_line = int'(wr_line);
      end
      mon_r = int'(wr_data[23:16]);
      check_eq("wr_tag", wr_data[7:0], 8'h5A);
      check_eq("wr_pix", wr_data[15:8], (int'(wr_addr) + h_start_exp) & 255);
      check_eq("wr_addr_range", (int'(wr_addr) < h_active_exp), 1);
      check_eq("wr_line_in_window",
               (mon_r >= v_start_exp) && (mon_r < v_start_exp + v_active_exp), 1);
      check_eq("wr_slot", wr_line, (((mon_r - v_start_exp) % 40) + 40) % 40);
      check_eq("wr_latency", pix_ce, 1'b0);
    end
  end

  task automatic clear_counts();
    wr_count   = 0;
    fs_count   = 0;
    got_first  = 1'b0;
    first_line = -1;
  endtask

  task automatic send_line(input int lnum, input int vs_from, input int vs_to, input int rst_at);
    for (int p = 0; p < 64; p++) begin
      @(posedge PCLK); #1;
      if (!reset_n) reset_n = 1'b1;
      pix_ce   = 1'b1;
      HSYNC_in = (p < 4) ? 1'b0 : 1'b1;
      VSYNC_in = (p >= vs_from && p < vs_to) ? 1'b0 : 1'b1;
      R_in     = lnum[7:0];
      G_in     = 8'(p - 1);
      B_in     = 8'h5A;
      @(posedge PCLK); #1;
      if (p == rst_at) begin
        check_eq("wr_en_before_rst", wr_en, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("wr_en_in_rst", wr_en, 1'b0);
        check_eq("lpf_in_rst", lines_per_frame, 11'd0);
        check_eq("ppl_in_rst", pix_per_line, 12'd0);
        check_eq("wr_line_in_rst", wr_line, 6'd0);
      end
      pix_ce = 1'b0;
      R_in   = 8'hC3;
      G_in   = 8'hC3;
      B_in   = 8'hC3;
    end
  endtask

  task automatic send_frame();
    for (int n = 0; n < 52; n++) begin
      send_line(n, (n == 51) ? 20 : 0, (n == 51) ? 40 : 0, -1);
    end
  endtask

  task automatic send_idle(input int count);
    for (int k = 0; k < count; k++) begin
      @(posedge PCLK); #1;
      pix_ce   = 1'b1;
      HSYNC_in = 1'b1;
      VSYNC_in = 1'b1;
      @(posedge PCLK); #1;
      pix_ce = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    pix_ce   = 1'b0;
    HSYNC_in = 1'b1;
    VSYNC_in = 1'b1;
    R_in     = 8'd0;
    G_in     = 8'd0;
    B_in     = 8'd0;
    h_info   = 32'h0028_0008;
    v_info   = 32'h002C_0004;
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 9'd0);
    check_eq("rst_wr_line", wr_line, 6'd0);
    check_eq("rst_wr_data", wr_data, 24'd0);
    check_eq("rst_frame_start", frame_start, 1'b0);
    check_eq("rst_lpf", lines_per_frame, 11'd0);
    check_eq("rst_ppl", pix_per_line, 12'd0);
    check_eq("rst_sync_lost", sync_lost, 1'b0);
    @(posedge PCLK); #1;
    reset_n = 1'b1;

    // Lock-up frame: nothing captured until VSYNC then HSYNC have fallen.
    clear_counts();
    send_frame();
    check_eq("prelock_writes", wr_count, 0);
    check_eq("prelock_fs", fs_count, 0);

    clear_counts();
    send_frame();
    check_eq("f1_writes", wr_count, 1760);
    check_eq("f1_fs", fs_count, 1);
    check_eq("f1_first_slot", first_line, 0);
    check_eq("f1_ppl", pix_per_line, 12'd64);
    check_eq("f1_lpf_first_frame", lines_per_frame, 11'd0);
    check_eq("f1_final_slot", wr_line, 6'd4);

    clear_counts();
    send_frame();
    check_eq("f2_writes", wr_count, 1760);
    check_eq("f2_fs", fs_count, 1);
    check_eq("f2_lpf", lines_per_frame, 11'd52);

    // Sync loss after 4095 enabled pixels without an HSYNC fall.
    send_line(0, 0, 0, -1);
    send_idle(4031);
    check_eq("sync_lost_before", sync_lost, 1'b0);
    send_idle(1);
    check_eq("sync_lost_set", sync_lost, 1'b1);
    clear_counts();
    for (int n = 0; n < 8; n++) send_line(n, 0, 0, -1);
    check_eq("sync_lost_cleared", sync_lost, 1'b0);
    send_frame();
    check_eq("lost_no_writes", wr_count, 0);
    clear_counts();
    send_frame();
    check_eq("resume_writes", wr_count, 1760);
    check_eq("resume_fs", fs_count, 1);
    check_eq("resume_first_slot", first_line, 0);

    // Coincident HSYNC/VSYNC fall mid-frame.
    for (int n = 0; n < 10; n++) send_line(n, 0, 0, -1);
    check_eq("pre_coinc_lpf", lines_per_frame, 11'd52);
    clear_counts();
    send_line(10, 0, 20, -1);
    check_eq("coinc_no_writes", wr_count, 0);
    clear_counts();
    for (int n = 0; n < 6; n++) send_line(n, 0, 0, -1);
    check_eq("coinc_lpf", lines_per_frame, 11'd10);
    check_eq("coinc_fs", fs_count, 1);
    check_eq("coinc_writes", wr_count, 80);
    check_eq("coinc_first_slot", first_line, 0);

    // Reset in the middle of an active line.
    send_line(6, 0, 0, 30);
    clear_counts();
    for (int n = 7; n < 10; n++) send_line(n, 0, 0, -1);
    send_frame();
    check_eq("postrst_no_writes", wr_count, 0);
    clear_counts();
    send_frame();
    check_eq("postrst_writes", wr_count, 1760);
    check_eq("postrst_fs", fs_count, 1);
    check_eq("postrst_first_slot", first_line, 0);
    check_eq("postrst_lpf", lines_per_frame, 11'd0);

    // Zero-width window latched during vsync.
    h_info = 32'h0000_0008;
    send_frame();
    clear_counts();
    send_frame();
    check_eq("hact0_writes", wr_count, 0);
    check_eq("hact0_fs", fs_count, 1);
    check_eq("hact0_lpf", lines_per_frame, 11'd52);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cps3_linebuf_writer.md
Name: cps3_linebuf_writer

Overview:
- Capture-side counterpart of the output sync generator.
- Samples the CPS3 source video stream (HSYNC/VSYNC, negative polarity, 24-bit RGB with pixel clock-enable) and produces write strobes, pixel addresses and line-buffer indices into the shared 40-entry line buffer RAM.
- The output timing side reads from that same RAM.
- Also measures source line length and frame height for status readback.

Parameters:
- NUM_LINE_BUFFERS, 40, number of line slots in the line buffer; the line index wraps at this value.
- H_CNT_MAX, 4095, saturation value of the source pixel counter and the sync-loss timeout.

Ports:
- PCLK  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pix_ce  in  1  source pixel clock-enable; inputs are valid only when high.
- HSYNC_in  in  1  source hsync, active low.
- VSYNC_in  in  1  source vsync, active low.
- R_in/G_in/B_in  in  8 each  source pixel colour.
- h_info  in  32  [9:0] h_start (pixels from HSYNC fall to first active pixel); [24:16] h_active.
- v_info  in  32  [5:0] v_start (lines from frame sync to first active line); [24:16] v_active.
- wr_en  out  1  line-buffer write strobe.
- wr_addr  out  9  pixel index within the line.
- wr_line  out  6  line-buffer slot index, 0..NUM_LINE_BUFFERS-1.
- wr_data  out  24  {R,G,B}.
- frame_start  out  1  one-cycle pulse when the first active line begins.
- lines_per_frame  out  11  measured source lines in the last complete frame.
- pix_per_line  out  12  measured pix_ce count between the last two HSYNC falls.
- sync_lost  out  1  no HSYNC fall for H_CNT_MAX enabled pixels.

Behaviour:
- Reset values: every output is 0, the internal counters are 0, the FSM is WAIT_VS, and the prev_hs/prev_vs edge registers are 1.
- Edge detection: edges are evaluated only on pix_ce cycles by comparing against prev_hs/prev_vs, which update only on pix_ce.
- Config latch: while VSYNC_in=0 and pix_ce=1, latch h_start, h_active, v_start and v_active. Values stay frozen outside vsync.
- FSM states:
  - WAIT_VS: waiting for a VSYNC fall. Entered on reset and on sync_lost. A VSYNC fall moves to WAIT_HS.
  - WAIT_HS: waiting for the next HSYNC fall, so that vertical counting is aligned to a line start. On that fall:
    - lines_per_frame <= vcnt+1 (skipped for the first frame after reset).
    - vcnt <= 0, hcnt <= 0, state <= RUN.
  - RUN: normal capture. A VSYNC fall in RUN moves back to WAIT_HS.
- hcnt (12 bits):
  - HSYNC fall: hcnt <= 0; pix_per_line <= hcnt+1; vcnt increments, saturating at 2047.
  - Otherwise on pix_ce: hcnt increments, saturating at H_CNT_MAX.
  - When hcnt reaches H_CNT_MAX: sync_lost <= 1 and state <= WAIT_VS. sync_lost clears on the next HSYNC fall.
- Active window, evaluated in RUN on pix_ce: v_start <= vcnt < v_start+v_active and h_start <= hcnt < h_start+h_active.
  - Pixel write address = hcnt - h_start, 9 bits.
- Write pipeline: latency is exactly 1 cycle. The PCLK after an active pix_ce sample drives wr_en=1, wr_addr, wr_line and wr_data = registered {R_in,G_in,B_in}. wr_en is 0 on all other cycles.
- Line index, at the HSYNC fall that ends an active line:
  - wr_line <= wr_line+1; wraps NUM_LINE_BUFFERS-1 -> 0.
  - At the HSYNC fall where vcnt becomes v_start, wr_line <= 0 and frame_start pulses for 1 cycle. This overrides the increment when both occur together.
- Boundary rules:
  - h_active=0 or v_active=0: no writes.
  - A window exceeding the line (h_start+h_active > pix_per_line): writes stop at the HSYNC fall; no wrap into the next line.
  - HSYNC fall and VSYNC fall on the same pix_ce: the VSYNC fall takes priority (state -> WAIT_HS); the HSYNC fall is consumed only for the hcnt reset. WAIT_HS then completes on the following HSYNC fall.
  - reset_n asserted mid-line: outputs go to 0 immediately. After release, no writes occur until a full WAIT_VS -> WAIT_HS sequence has completed.

Test Plan:
- Synthetic 384x224 frame (h_start=64, h_active=384, v_start=16, v_active=224, 512 pixels/line, 262 lines, pix_ce every 2nd PCLK) -> per frame, 224 lines x 384 writes. wr_addr runs 0..383, wr_line follows 0..39 wrapping, lines_per_frame=262, pix_per_line=512.
- Pixel ramp data -> wr_data equals the input sampled exactly 1 PCLK earlier; the first write carries the pixel at hcnt=64.
- HSYNC held high for 4095 pix_ce -> sync_lost=1, no further writes. A new VSYNC fall followed by an HSYNC fall resumes capture with wr_line=0 and a frame_start pulse.
- Coincident HSYNC/VSYNC fall -> state WAIT_HS. vcnt resets on the next HSYNC fall; no writes occur in between.
- reset_n pulsed mid-active-line -> wr_en drops in the same cycle. No writes until the next VSYNC+HSYNC pair; lines_per_frame stays 0 for that first frame.
- h_active=0 latched during vsync -> zero wr_en pulses over a full frame; frame_start still pulses once.
